// File: rtl/mul_pkg.sv
// Shared constants for the MULT/MULTU sequencer.
// State codes, operand sizing and the signed-select level.
package mul_pkg;
  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ABS_A  = 3'd1;
  localparam logic [2:0] S_ABS_B  = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_NEG_LO = 3'd4;
  localparam logic [2:0] S_NEG_HI = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic OP_SIGNED   = 1'b1;
  localparam logic OP_UNSIGNED = 1'b0;
endpackage

// File: rtl/mul_seq_if.sv
// Control-unit side of the multiplier: request, status and result.
// The master issues operations; the slave is the sequencer.
interface mul_seq_if;
  import mul_pkg::*;

  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, signed_op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, signed_op, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_seq_add32.sv
// Add32: the datapath's 32-bit adder with carry out.
// Shared by every step of the multiply sequence.
module add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        carry
);
  assign {carry, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/mul_seq.sv
// MULT/MULTU sequencer: sign fix-up, 32 shift-add steps, negate.
// All arithmetic goes through one Add32 instance.
module mul_seq
  import mul_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  mul_seq_if.slave bus
);
  logic [2:0]       state, state_n;
  logic [WIDTH-1:0] mcand, mcand_n;
  logic [WIDTH-1:0] acc_hi, hi_n;
  logic [WIDTH-1:0] acc_lo, lo_n;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             neg, neg_n;
  logic             sgn, sgn_n;
  logic             c0, c0_n;

  logic [WIDTH-1:0] add_a, add_b, add_s;
  logic             add_c;
  logic [WIDTH:0]   s;

  add32 u_add (
    .a    (add_a),
    .b    (add_b),
    .sum  (add_s),
    .carry(add_c)
  );

  always_comb begin
    add_a = '0;
    add_b = '0;
    unique case (state)
      S_ABS_A:  begin add_a = ~mcand;  add_b = WIDTH'(1); end
      S_ABS_B:  begin add_a = ~acc_lo; add_b = WIDTH'(1); end
      S_RUN:    begin add_a = acc_hi;  add_b = mcand;     end
      S_NEG_LO: begin add_a = ~acc_lo; add_b = WIDTH'(1); end
      S_NEG_HI: begin add_a = ~acc_hi; add_b = WIDTH'(c0); end
      default:  begin add_a = '0;      add_b = '0;        end
    endcase
  end

  always_comb begin
    state_n = state;
    mcand_n = mcand;
    hi_n    = acc_hi;
    lo_n    = acc_lo;
    cnt_n   = cnt;
    neg_n   = neg;
    sgn_n   = sgn;
    c0_n    = c0;
    s       = acc_lo[0] ? {add_c, add_s} : {1'b0, acc_hi};
    unique case (state)
      S_IDLE, S_DONE: begin
        state_n = S_IDLE;
        if (bus.start) begin
          mcand_n = bus.a;
          hi_n    = '0;
          lo_n    = bus.b;
          cnt_n   = '0;
          sgn_n   = (bus.signed_op == OP_SIGNED);
          neg_n   = sgn_n & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          state_n = sgn_n ? S_ABS_A : S_RUN;
        end
      end
      S_ABS_A: begin
        if (mcand[WIDTH-1]) mcand_n = add_s;
        state_n = S_ABS_B;
      end
      S_ABS_B: begin
        if (acc_lo[WIDTH-1]) lo_n = add_s;
        state_n = S_RUN;
      end
      S_RUN: begin
        hi_n  = s[WIDTH:1];
        lo_n  = {s[0], acc_lo[WIDTH-1:1]};
        cnt_n = cnt + 1'b1;
        if (cnt == CNT_W'(WIDTH-1))
          state_n = sgn ? S_NEG_LO : S_DONE;
      end
      S_NEG_LO: begin
        if (neg) begin
          lo_n = add_s;
          c0_n = add_c;
        end
        state_n = S_NEG_HI;
      end
      S_NEG_HI: begin
        if (neg) hi_n = add_s;
        state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      sgn    <= 1'b0;
      c0     <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      state  <= state_n;
      mcand  <= mcand_n;
      acc_hi <= hi_n;
      acc_lo <= lo_n;
      cnt    <= cnt_n;
      neg    <= neg_n;
      sgn    <= sgn_n;
      c0     <= c0_n;
      // result words only move on the edge that enters DONE
      if (state_n == S_DONE && state != S_DONE) begin
        hi_q <= hi_n;
        lo_q <= lo_n;
      end
    end
  end

  assign bus.busy = (state != S_IDLE) && (state != S_DONE);
  assign bus.done = (state == S_DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: cycle-level model of the handshake plus
// directed MULT/MULTU vectors with hand-computed products.
module tb_mul_seq;
  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_done = 0;

  mul_seq_if bus();

  mul_seq dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string nm,
                                input logic [63:0] act,
                                input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic logic [63:0] product(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic sg);
    logic signed [63:0] sx, sy;
    if (sg) begin
      sx = $signed({{32{x[31]}}, x});
      sy = $signed({{32{y[31]}}, y});
      return 64'(sx * sy);
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  // model: an accepted op finishes a fixed number of edges later
  int          m_cnt;
  logic        m_done;
  logic [63:0] m_prod;
  logic [31:0] m_hi, m_lo;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_done = 0; m_hi = 0; m_lo = 0; m_prod = 0;
    end else if (m_cnt == 0 && bus.start) begin
      m_cnt  = bus.signed_op ? 36 : 32;
      m_prod = product(bus.a, bus.b, bus.signed_op);
      m_done = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      m_done = (m_cnt == 0);
      if (m_done) {m_hi, m_lo} = m_prod;
    end else begin
      m_done = 0;
    end
  end

  always @(negedge clk) begin
    check("busy", 64'(bus.busy), 64'(m_cnt > 0));
    check("done", 64'(bus.done), 64'(m_done));
    check("hi",   64'(bus.hi),   64'(m_hi));
    check("lo",   64'(bus.lo),   64'(m_lo));
    if (bus.done) n_done++;
  end

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 100) begin
      @(posedge clk); n++; #1;
    end
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_,
                        input logic ts, input logic [31:0] eh,
                        input logic [31:0] el, input int elat,
                        input string nm);
    int n;
    @(negedge clk);
    bus.start = 1; bus.a = ta; bus.b = tb_; bus.signed_op = ts;
    @(posedge clk);
    @(negedge clk);
    bus.start = 0;
    bus.b = 32'h1234_5678;
    n = 0;
    while (!bus.done && n < 100) begin
      @(posedge clk); n++; #1;
    end
    check({nm, "_lat"}, 64'(n), 64'(elat));
    check({nm, "_hi"}, 64'(bus.hi), 64'(eh));
    check({nm, "_lo"}, 64'(bus.lo), 64'(el));
  endtask

  initial begin
    int n;
    int d0;
    rst_n = 0;
    bus.start = 0; bus.signed_op = 0; bus.a = 0; bus.b = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 0);
    check("rst_done", 64'(bus.done), 0);
    check("rst_hi", 64'(bus.hi), 0);
    check("rst_lo", 64'(bus.lo), 0);
    #1 rst_n = 1;
    repeat (2) @(negedge clk);

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,
           32'hFFFF_FFFE, 32'h0000_0001, 32, "mulu_max");
    run_op(32'h0002_0002, 32'h000E_000D, 0,
           32'h0000_001C, 32'h0036_001A, 32, "mulu_mix");
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1,
           32'hFFFF_FFFF, 32'hFFFF_FFFF, 36, "mul_m1");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1,
           32'h0000_0000, 32'h8000_0000, 36, "mul_min");
    run_op(32'h0000_0000, 32'hFFFF_FFFF, 1,
           32'h0000_0000, 32'h0000_0000, 36, "mul_zero");

    // start held high; second op accepted from the DONE cycle
    @(negedge clk);
    bus.a = 3; bus.b = 5; bus.signed_op = 0; bus.start = 1;
    @(posedge clk);
    d0 = n_done;
    @(negedge clk);
    bus.b = 9;
    wait_done(n);
    check("held1_lat", 64'(n), 32);
    check("held1_lo", 64'(bus.lo), 15);
    @(posedge clk); #1;
    check("held_reaccept", 64'(bus.busy), 1);
    wait_done(n);
    bus.start = 0;
    check("held2_lat", 64'(n), 32);
    check("held2_lo", 64'(bus.lo), 27);
    repeat (3) @(negedge clk);
    check("held_pulses", 64'(n_done - d0), 2);

    // reset in the middle of RUN
    @(negedge clk);
    bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF;
    bus.signed_op = 0; bus.start = 1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("abort_busy", 64'(bus.busy), 0);
    check("abort_done", 64'(bus.done), 0);
    check("abort_hi", 64'(bus.hi), 0);
    check("abort_lo", 64'(bus.lo), 0);
    d0 = n_done;
    @(negedge clk);
    #2 rst_n = 1;
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(n_done - d0), 0);
    run_op(32'd7, 32'd6, 0, 32'd0, 32'd42, 32, "mulu_7x6");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
